coord_stream_gen: RTL and testbench

Parametrised, programmable pixel-coordinate stream generator for the fractal render pipeline. Walks a V_RES × H_RES raster in row-major order. Emits per pixel:
- a signed fixed-point plane coordinate (x, y), derived from a runtime origin and step,
- the integer column/row indices,
- first/lastx/lastframe markers,

all under a valid/ready handshake. New view settings (pan/zoom) take effect only at frame boundaries, so no frame ever mixes two views.

---
 rtl/coord_stream_gen_if.sv | 33 +++
 rtl/coord_stream_gen.sv | 164 ++++++++++++++++
 tb/tb_coord_stream_gen.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coord_stream_gen_if.sv
// Bundle for coord_stream_gen: run/config inputs and the pixel-coordinate output stream.
// master = generator side, slave = consumer/driver side.
interface coord_stream_gen_if #(
  parameter int unsigned COORD_W = 16,
  parameter int unsigned STEP_W  = 16,
  parameter int unsigned IDX_W   = 10
);
  logic               enable;
  logic [COORD_W-1:0] cfg_x0;
  logic [COORD_W-1:0] cfg_y0;
  logic [STEP_W-1:0]  cfg_step;
  logic               cfg_update;
  logic               out_ready;
  logic               out_valid;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [IDX_W-1:0]   col;
  logic [IDX_W-1:0]   row;
  logic               first;
  logic               lastx;
  logic               lastframe;
  logic [15:0]        frame_cnt;

  modport master (
    input  enable, cfg_x0, cfg_y0, cfg_step, cfg_update, out_ready,
    output out_valid, x, y, col, row, first, lastx, lastframe, frame_cnt
  );

  modport slave (
    output enable, cfg_x0, cfg_y0, cfg_step, cfg_update, out_ready,
    input  out_valid, x, y, col, row, first, lastx, lastframe, frame_cnt
  );
endinterface

// File: rtl/coord_stream_gen.sv
// Row-major raster walker emitting fixed-point plane coordinates under valid/ready.
// Define COORD_STREAM_GEN_FRAME_CNT_EN to implement the completed-frame counter.
module coord_stream_gen #(
  parameter int unsigned H_RES   = 640,
  parameter int unsigned V_RES   = 480,
  parameter int unsigned COORD_W = 16,
  parameter int unsigned STEP_W  = 16,
  parameter int unsigned IDX_W   = 10
) (
  input  logic               clk,
  input  logic               reset,
  coord_stream_gen_if.master bus
);
  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam int                 DefX0Int = -int'(H_RES / 2);
  localparam logic [COORD_W-1:0] DefX0    = COORD_W'(DefX0Int);
  localparam logic [COORD_W-1:0] DefY0    = COORD_W'(V_RES / 2);
  localparam logic [STEP_W-1:0]  DefStep  = STEP_W'(1);
  localparam logic [IDX_W-1:0]   ColLast  = IDX_W'(H_RES - 1);
  localparam logic [IDX_W-1:0]   RowLast  = IDX_W'(V_RES - 1);

  state_e             r_state, w_state_d;
  logic [COORD_W-1:0] r_pend_x0, r_pend_y0, w_pend_x0_d, w_pend_y0_d;
  logic [STEP_W-1:0]  r_pend_step, w_pend_step_d;
  logic [COORD_W-1:0] r_act_x0, r_act_y0, w_act_x0_d, w_act_y0_d;
  logic [STEP_W-1:0]  r_act_step, w_act_step_d;
  logic [COORD_W-1:0] r_x, r_y, w_x_d, w_y_d;
  logic [IDX_W-1:0]   r_col, r_row, w_col_d, w_row_d;
  logic               r_first, r_lastx, r_lastframe;
  logic               w_first_d, w_lastx_d, w_lastframe_d;
  logic               w_xfer, w_load, w_move;
  logic [COORD_W:0]   w_step_ext, w_x_inc, w_y_dec;

  assign w_xfer     = (r_state == StRun) && bus.out_ready;
  assign w_step_ext = (COORD_W + 1)'(r_act_step);
  assign w_x_inc    = {1'b0, r_x} + w_step_ext;
  assign w_y_dec    = {1'b0, r_y} - w_step_ext;

  always_comb begin
    w_state_d     = r_state;
    // Pending next-value doubles as the bypass path into a frame that starts this edge.
    w_pend_x0_d   = bus.cfg_update ? bus.cfg_x0   : r_pend_x0;
    w_pend_y0_d   = bus.cfg_update ? bus.cfg_y0   : r_pend_y0;
    w_pend_step_d = bus.cfg_update ? bus.cfg_step : r_pend_step;
    w_act_x0_d    = r_act_x0;
    w_act_y0_d    = r_act_y0;
    w_act_step_d  = r_act_step;
    w_x_d         = r_x;
    w_y_d         = r_y;
    w_col_d       = r_col;
    w_row_d       = r_row;
    w_load        = 1'b0;
    w_move        = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (bus.enable) begin
          w_state_d = StRun;
          w_load    = 1'b1;
        end
      end
      StRun: begin
        if (w_xfer) begin
          if (r_lastframe) begin
            if (bus.enable) w_load = 1'b1;
            else            w_state_d = StIdle;
          end else if (r_lastx) begin
            w_move  = 1'b1;
            w_col_d = '0;
            w_row_d = r_row + 1'b1;
            w_x_d   = r_act_x0;
            w_y_d   = w_y_dec[COORD_W-1:0];
          end else begin
            w_move  = 1'b1;
            w_col_d = r_col + 1'b1;
            w_x_d   = w_x_inc[COORD_W-1:0];
          end
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_load) begin
      w_move       = 1'b1;
      w_act_x0_d   = w_pend_x0_d;
      w_act_y0_d   = w_pend_y0_d;
      w_act_step_d = w_pend_step_d;
      w_x_d        = w_pend_x0_d;
      w_y_d        = w_pend_y0_d;
      w_col_d      = '0;
      w_row_d      = '0;
    end

    // Markers are decoded from the next position so they register alongside the payload.
    w_first_d     = r_first;
    w_lastx_d     = r_lastx;
    w_lastframe_d = r_lastframe;
    if (w_move) begin
      w_first_d     = (w_col_d == '0) && (w_row_d == '0);
      w_lastx_d     = (w_col_d == ColLast);
      w_lastframe_d = (w_col_d == ColLast) && (w_row_d == RowLast);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_pend_x0   <= DefX0;
      r_pend_y0   <= DefY0;
      r_pend_step <= DefStep;
      r_act_x0    <= DefX0;
      r_act_y0    <= DefY0;
      r_act_step  <= DefStep;
      r_x         <= '0;
      r_y         <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_first     <= 1'b0;
      r_lastx     <= 1'b0;
      r_lastframe <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_pend_x0   <= w_pend_x0_d;
      r_pend_y0   <= w_pend_y0_d;
      r_pend_step <= w_pend_step_d;
      r_act_x0    <= w_act_x0_d;
      r_act_y0    <= w_act_y0_d;
      r_act_step  <= w_act_step_d;
      r_x         <= w_x_d;
      r_y         <= w_y_d;
      r_col       <= w_col_d;
      r_row       <= w_row_d;
      r_first     <= w_first_d;
      r_lastx     <= w_lastx_d;
      r_lastframe <= w_lastframe_d;
    end
  end

`ifdef COORD_STREAM_GEN_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;
  logic        w_frame_done;

  assign w_frame_done = w_xfer && r_lastframe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_frame_cnt <= '0;
    else if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign bus.frame_cnt = r_frame_cnt;
`else
  assign bus.frame_cnt = '0;
`endif

  assign bus.out_valid = (r_state == StRun);
  assign bus.x         = r_x;
  assign bus.y         = r_y;
  assign bus.col       = r_col;
  assign bus.row       = r_row;
  assign bus.first     = r_first;
  assign bus.lastx     = r_lastx;
  assign bus.lastframe = r_lastframe;
endmodule

// File: tb/tb_coord_stream_gen.sv
// Self-checking bench for coord_stream_gen on a small 4x12 raster; expected beats come
// from closed-form arithmetic (x0 + col*step, y0 - row*step) over a bench-side config model.
module tb_coord_stream_gen;
  localparam int H  = 4;
  localparam int V  = 12;
  localparam int N  = H * V;
  localparam int CW = 16;
  localparam int SW = 16;
  localparam int IW = 4;

  typedef logic [2*CW+2*IW+2:0] beat_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   fc_model = 0;
  logic [15:0] p_x0, p_y0, p_step;
  logic [15:0] a_x0, a_y0, a_step;

  coord_stream_gen_if #(.COORD_W(CW), .STEP_W(SW), .IDX_W(IW)) bus ();

  coord_stream_gen #(
    .H_RES(H), .V_RES(V), .COORD_W(CW), .STEP_W(SW), .IDX_W(IW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void set_defaults();
    p_x0   = 16'hFFFE;  // -(H/2)
    p_y0   = 16'd6;     // V/2
    p_step = 16'd1;
  endfunction

  function automatic void start_frame();
    a_x0 = p_x0; a_y0 = p_y0; a_step = p_step;
  endfunction

  function automatic beat_t exp_beat(int k);
    int col, row;
    logic [15:0] x, y;
    col = k % H;
    row = k / H;
    x = a_x0 + 16'(col * a_step);
    y = a_y0 - 16'(row * a_step);
    return {x, y, IW'(col), IW'(row), k == 0, col == H - 1, k == N - 1};
  endfunction

  function automatic beat_t act_beat();
    return {bus.x, bus.y, bus.col, bus.row, bus.first, bus.lastx, bus.lastframe};
  endfunction

  function automatic logic [15:0] exp_fc();
`ifdef COORD_STREAM_GEN_FRAME_CNT_EN
    return 16'(fc_model);
`else
    return 16'd0;
`endif
  endfunction

  task automatic test_reset();
    bus.enable = 1'b0; bus.out_ready = 1'b0; bus.cfg_update = 1'b0;
    bus.cfg_x0 = '0; bus.cfg_y0 = '0; bus.cfg_step = '0;
    reset = 1'b1;
    set_defaults();
    repeat (2) @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b want=0", bus.out_valid);
    end
    total++;
    if (act_beat() !== '0) begin
      bad++; $display("FAIL reset_payload got=%h want=0", act_beat());
    end
    total++;
    if (bus.frame_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_frame_cnt got=%h want=0", bus.frame_cnt);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL idle_valid got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_default_frame();
    beat_t e;
    bus.enable = 1'b1; bus.out_ready = 1'b1;
    start_frame();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      e = exp_beat(k);
      total++;
      if (bus.out_valid !== 1'b1 || act_beat() !== e) begin
        bad++;
        $display("FAIL default k=%0d got v=%b %h want v=1 %h", k, bus.out_valid, act_beat(), e);
      end
      if (k == 0) begin
        total++;
        if (bus.frame_cnt !== exp_fc()) begin
          bad++; $display("FAIL default_fc got=%h want=%h", bus.frame_cnt, exp_fc());
        end
      end
    end
    fc_model++;
  endtask

  task automatic test_random_stall();
    beat_t e, prev;
    bit    have_prev = 1'b0;
    int    k = 0;
    int    cycles = 0;
    start_frame();
    while (k < N && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      bus.out_ready = 1'($urandom % 2);
      e = exp_beat(k);
      total++;
      if (bus.out_valid !== 1'b1 || act_beat() !== e) begin
        bad++;
        $display("FAIL stall k=%0d got v=%b %h want v=1 %h", k, bus.out_valid, act_beat(), e);
      end
      if (k == 0 && !have_prev) begin
        total++;
        if (bus.frame_cnt !== exp_fc()) begin
          bad++; $display("FAIL stall_fc got=%h want=%h", bus.frame_cnt, exp_fc());
        end
      end
      if (have_prev) begin
        total++;
        if (act_beat() !== prev) begin
          bad++; $display("FAIL stall_hold k=%0d got=%h want=%h", k, act_beat(), prev);
        end
      end
      if (bus.out_ready) begin
        k++;
        have_prev = 1'b0;
      end else begin
        have_prev = 1'b1;
        prev = act_beat();
      end
    end
    total++;
    if (k != N) begin
      bad++; $display("FAIL stall_transfers got=%0d want=%0d", k, N);
    end
    fc_model++;
  endtask

  task automatic test_cfg_update();
    beat_t e;
    start_frame();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      bus.out_ready = 1'b1; bus.cfg_update = 1'b0;
      if (k == 5) begin
        bus.cfg_x0 = 16'($urandom); bus.cfg_y0 = 16'($urandom); bus.cfg_step = 16'($urandom);
        bus.cfg_update = 1'b1;
      end
      if (k == 10) begin
        bus.cfg_x0 = 16'd100; bus.cfg_y0 = 16'hFFCE; bus.cfg_step = 16'd4;
        bus.cfg_update = 1'b1;
        p_x0 = 16'd100; p_y0 = 16'hFFCE; p_step = 16'd4;
      end
      e = exp_beat(k);
      total++;
      if (bus.out_valid !== 1'b1 || act_beat() !== e) begin
        bad++; $display("FAIL cfg_old k=%0d got v=%b %h want %h", k, bus.out_valid, act_beat(), e);
      end
    end
    fc_model++;
    start_frame();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      bus.cfg_update = 1'b0;
      // Pulse coincides with the lastframe transfer: must land in the next frame.
      if (k == N - 1) begin
        bus.cfg_x0 = 16'h7FFC; bus.cfg_y0 = 16'($urandom); bus.cfg_step = 16'd8;
        bus.cfg_update = 1'b1;
        p_x0 = bus.cfg_x0; p_y0 = bus.cfg_y0; p_step = 16'd8;
      end
      e = exp_beat(k);
      total++;
      if (bus.out_valid !== 1'b1 || act_beat() !== e) begin
        bad++; $display("FAIL cfg_new k=%0d got v=%b %h want %h", k, bus.out_valid, act_beat(), e);
      end
      if (k == 0) begin
        total++;
        if (bus.x !== 16'd100 || bus.y !== 16'hFFCE) begin
          bad++; $display("FAIL cfg_beat0 got=%h,%h want=0064,ffce", bus.x, bus.y);
        end
      end
      if (k == 1) begin
        total++;
        if (bus.x !== 16'd104) begin
          bad++; $display("FAIL cfg_beat1 got=%h want=0068", bus.x);
        end
      end
      if (k == H) begin
        total++;
        if (bus.y !== 16'hFFCA) begin
          bad++; $display("FAIL cfg_row1 got=%h want=ffca", bus.y);
        end
      end
    end
    fc_model++;
  endtask

  task automatic test_wrap();
    beat_t e;
    logic [15:0] wrap_x [4];
    wrap_x[0] = 16'h7FFC; wrap_x[1] = 16'h8004; wrap_x[2] = 16'h800C; wrap_x[3] = 16'h8014;
    start_frame();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      bus.cfg_update = 1'b0;
      e = exp_beat(k);
      total++;
      if (bus.out_valid !== 1'b1 || act_beat() !== e) begin
        bad++; $display("FAIL wrap k=%0d got v=%b %h want %h", k, bus.out_valid, act_beat(), e);
      end
      if (k < 4) begin
        total++;
        if (bus.x !== wrap_x[k]) begin
          bad++; $display("FAIL wrap_x k=%0d got=%h want=%h", k, bus.x, wrap_x[k]);
        end
      end
    end
    fc_model++;
  endtask

  task automatic test_enable_drop();
    beat_t e;
    start_frame();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      if (k == 10 * H) bus.enable = 1'b0;
      e = exp_beat(k);
      total++;
      if (bus.out_valid !== 1'b1 || act_beat() !== e) begin
        bad++; $display("FAIL drop k=%0d got v=%b %h want %h", k, bus.out_valid, act_beat(), e);
      end
    end
    fc_model++;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL drop_idle got=%b want=0", bus.out_valid);
    end
    total++;
    if (bus.frame_cnt !== exp_fc()) begin
      bad++; $display("FAIL drop_fc got=%h want=%h", bus.frame_cnt, exp_fc());
    end
    repeat (3) @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL drop_stay_idle got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    beat_t e;
    bus.enable = 1'b1;
    start_frame();
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      e = exp_beat(k);
      total++;
      if (bus.out_valid !== 1'b1 || act_beat() !== e) begin
        bad++; $display("FAIL pre_rst k=%0d got v=%b %h want %h", k, bus.out_valid, act_beat(), e);
      end
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || act_beat() !== '0) begin
      bad++; $display("FAIL async_rst got v=%b %h want v=0 0", bus.out_valid, act_beat());
    end
    fc_model = 0;
    set_defaults();
    total++;
    if (bus.frame_cnt !== 16'd0) begin
      bad++; $display("FAIL async_rst_fc got=%h want=0", bus.frame_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    start_frame();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      if (k == N - 1) bus.enable = 1'b0;
      e = exp_beat(k);
      total++;
      if (bus.out_valid !== 1'b1 || act_beat() !== e) begin
        bad++; $display("FAIL post_rst k=%0d got v=%b %h want %h", k, bus.out_valid, act_beat(), e);
      end
    end
    fc_model++;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.frame_cnt !== exp_fc()) begin
      bad++;
      $display("FAIL post_rst_end got v=%b fc=%h want v=0 fc=%h", bus.out_valid, bus.frame_cnt,
               exp_fc());
    end
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_random_stall();
    test_cfg_update();
    test_wrap();
    test_enable_drop();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
